// File: rtl/pipe_pkg.sv
// Shared pipeline types: opcodes, hazard FSM states, forwarding selects and
// the register-write port descriptor used by the hazard comparators.
package pipe_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } wr_port_t;

  // x0 is hard-wired zero, so a write to it never produces a hazard.
  function automatic logic rd_hit(logic [4:0] rs, logic used, wr_port_t w);
    return used & w.we & (w.rd != 5'd0) & (rs == w.rd);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Single-source operand comparator: forwarding select plus load-use hit.
module hazard_fwd_match
  import pipe_pkg::*;
(
  input  logic [4:0] i_rs_addr,
  input  logic       i_rs_used,
  input  wr_port_t   i_mem,
  input  logic       i_mem_is_load,
  input  wr_port_t   i_wb,
  output logic [1:0] o_sel,
  output logic       o_lu_hit
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = rd_hit(i_rs_addr, i_rs_used, i_mem);
  assign w_wb_hit  = rd_hit(i_rs_addr, i_rs_used, i_wb);

  // A load in MEM has no data yet; the load-use stall re-resolves it from WB.
  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit)     o_sel = i_mem_is_load ? FWD_RF : FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

  assign o_lu_hit = w_mem_hit & i_mem_is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use / memory-wait stall and branch-flush controller for
// the 5-stage pipeline, with a sticky data-memory timeout flag.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_RS       = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_RS*5-1:0]   ex_rs_addr,
  input  logic [NUM_RS-1:0]     ex_rs_used,
  input  logic [4:0]            mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic                  mem_is_load,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  input  logic [4:0]            wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic                  br_taken,
  output logic [NUM_RS*2-1:0]   fwd_sel,
  output logic                  stall_if,
  output logic                  stall_dec,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  bubble_mem,
  output logic                  bubble_wb,
  output logic                  flush_if,
  output logic                  flush_dec,
  output logic                  mem_timeout,
  output logic [1:0]            state_o
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] L_TO = CNT_W'(WAIT_TIMEOUT);

  hz_state_t               r_state;
  hz_state_t               w_nxt;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic                    r_timeout;

  wr_port_t                w_mem;
  wr_port_t                w_wb;
  logic [NUM_RS-1:0][1:0]  w_sel;
  logic [NUM_RS-1:0]       w_lu_src;
  logic                    w_lu_hit;
  logic                    w_mwait;

  logic w_s_if, w_s_dec, w_s_ex, w_s_mem, w_b_mem, w_b_wb, w_any_stall;

  assign w_mem = '{rd: mem_rd_addr, we: mem_reg_write};
  assign w_wb  = '{rd: wb_rd_addr,  we: wb_reg_write};

  for (genvar i = 0; i < NUM_RS; i++) begin : g_src
    hazard_fwd_match u_match (
      .i_rs_addr     (ex_rs_addr[5*i +: 5]),
      .i_rs_used     (ex_rs_used[i]),
      .i_mem         (w_mem),
      .i_mem_is_load (mem_is_load),
      .i_wb          (w_wb),
      .o_sel         (w_sel[i]),
      .o_lu_hit      (w_lu_src[i])
    );
  end

  assign w_lu_hit = |w_lu_src;
  assign w_mwait  = mem_req & ~dmem_ready;

  always_comb begin
    w_nxt   = r_state;
    w_s_if  = 1'b0;
    w_s_dec = 1'b0;
    w_s_ex  = 1'b0;
    w_s_mem = 1'b0;
    w_b_mem = 1'b0;
    w_b_wb  = 1'b0;
    unique case (r_state)
      RUN, LU_STALL: begin
        if (w_mwait) begin
          {w_s_if, w_s_dec, w_s_ex, w_s_mem, w_b_wb} = '1;
          w_nxt = MEM_WAIT;
        end else if (w_lu_hit && r_state == RUN) begin
          {w_s_if, w_s_dec, w_s_ex, w_b_mem} = '1;
          w_nxt = LU_STALL;
        end else begin
          w_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (w_mwait) begin
          {w_s_if, w_s_dec, w_s_ex, w_s_mem, w_b_wb} = '1;
          w_nxt = MEM_WAIT;
        end else if (w_lu_hit) begin
          // The completing access was a load that EX still depends on.
          {w_s_if, w_s_dec, w_s_ex, w_b_mem} = '1;
          w_nxt = LU_STALL;
        end else begin
          w_nxt = RUN;
        end
      end
      default: w_nxt = RUN;
    endcase
  end

  assign w_any_stall = w_s_if | w_s_dec | w_s_ex | w_s_mem;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == MEM_WAIT && r_wait_cnt == L_TO) r_timeout <= 1'b1;
      if (w_nxt == MEM_WAIT) begin
        if (r_state != MEM_WAIT)   r_wait_cnt <= CNT_W'(1);
        else if (r_wait_cnt < L_TO) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign fwd_sel     = w_sel & {(NUM_RS*2){RST_N}};
  assign stall_if    = w_s_if  & RST_N;
  assign stall_dec   = w_s_dec & RST_N;
  assign stall_ex    = w_s_ex  & RST_N;
  assign stall_mem   = w_s_mem & RST_N;
  assign bubble_mem  = w_b_mem & RST_N;
  assign bubble_wb   = w_b_wb  & RST_N;
  // EX is held during any stall, so a taken branch waits for the free cycle.
  assign flush_if    = br_taken & ~w_any_stall & RST_N;
  assign flush_dec   = br_taken & ~w_any_stall & RST_N;
  assign mem_timeout = r_timeout;
  assign state_o     = r_state;

endmodule
